data_sram_responder: RTL and testbench
======================================

Name: data_sram_responder

Overview:
- Data-side memory responder. It services the pipeline's data SRAM port, which EX drives with en/wen/addr/wdata, and returns data_sram_rdata, which the MEM stage consumes one stage later.
- Word-organised RAM with byte-lane writes and registered reads.
- Optional programmable wait states; while a request is pending it raises a stall request to the pipeline controller.
- Flags illegal byte-enable patterns.

Parameters:
- ADDR_W, 10, word-address width; depth = 2**ADDR_W words of 32 bits.
- WAIT_CYCLES, 0, extra cycles per access; 0 = single-cycle responder; legal range 0..15.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  asynchronous reset, active-low.
- data_sram_en  in  1  request valid this cycle.
- data_sram_wen  in  4  byte-lane write enables; 0000 = read, nonzero = write.
- data_sram_addr  in  32  byte address.
- data_sram_wdata  in  32  write data; lane i = bits 8i+7:8i.
- data_sram_rdata  out  32  registered read data, held until the next read completes.
- stallreq_for_mem  out  1  combinational; high while the pipeline must hold EX/MEM.
- data_sram_err  out  1  registered one-cycle pulse for an illegal wen pattern.

Behaviour:
- Reset (rst=0, asynchronous):
  - rdata=0, err=0, state=IDLE, cnt=0, stallreq=0.
  - RAM contents are not reset.
  - Reset asserted mid-BUSY aborts the pending access: no write occurs and rdata is unchanged from its reset value 0.
- Addressing:
  - Word index = addr[ADDR_W+1:2].
  - addr[1:0] are ignored; lane selection comes only from wen.
  - Higher address bits are ignored, so addresses alias modulo depth.
- Legal wen patterns: 0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - Any other pattern with en=1 is accepted like a write but performs no write.
  - err pulses high for exactly one cycle, the cycle after the access completes.
- States are IDLE and BUSY, with a 4-bit counter cnt.
  - IDLE, en=0: nothing happens.
  - IDLE, en=1, WAIT_CYCLES=0: the access is performed at this edge.
    - Read: rdata <= RAM[idx], visible in the next cycle.
    - Write: the enabled lanes update; rdata is unchanged.
  - IDLE, en=1, WAIT_CYCLES>0: latch en/wen/addr/wdata, cnt <= WAIT_CYCLES, go to BUSY.
  - BUSY: request inputs are ignored.
    - cnt>1: cnt decrements.
    - cnt==1: the latched access is performed at this edge, then go to IDLE.
- stallreq_for_mem = (IDLE & en & WAIT_CYCLES!=0) | (BUSY & cnt>1).
  - The stage after the completing edge sees valid rdata with no stall.
- Latency:
  - Read data is valid WAIT_CYCLES+1 edges after the accept edge.
  - Back-to-back requests are accepted every cycle when WAIT_CYCLES=0, and every WAIT_CYCLES+1 cycles otherwise.
- A read of a word written by the immediately preceding access returns the new data; a write always completes before the next access is accepted.
- No simultaneous read and write can occur: one access per request.
- rdata changes only on completion of a read; writes, idle cycles and errors leave it stable, so a stalled MEM stage re-samples the same value.

Decomposition:
- Shared defines header:
  - WAIT_W = 4.
  - Legal-wen pattern constants.
  - `StallBus stall-request index used by the controller.
- One sub-module, data_sram_array: the 2**ADDR_W x 32 RAM with byte-lane write and registered read.
- The FSM, counter, wen checker and stallreq logic live in the top module.

Test Plan:
- WAIT=0, write wen=1111 addr=0x10 wdata=0xDEADBEEF, then read addr=0x10 -> rdata=0xDEADBEEF one cycle after the read edge; stallreq stays 0 throughout.
- Byte/half lanes: write 0x11223344 with wen=1111 to 0x20, then wdata=0x000000AA wen=0001, then wdata=0xBBBB0000 wen=1100, then read 0x20 -> 0xBBBB33AA.
- WAIT=3, read 0x10 -> stallreq high for 3 cycles (accept cycle plus cnt=3,2), low with cnt=1; rdata=0xDEADBEEF valid 4 edges after accept; inputs changed during BUSY have no effect.
- Illegal wen=0101 write to 0x20 -> err high exactly one cycle; a following read of 0x20 is unchanged at 0xBBBB33AA; rdata is not disturbed by the error.
- Reset mid-BUSY: WAIT=3, issue write 0x55555555 to 0x30 (prior contents 0), assert rst=0 after 1 cycle -> stallreq, rdata and err go 0 immediately; after release, a read of 0x30 returns 0.
- Alias and hold: with ADDR_W=10, write 0x12345678 to 0x1004, read 0x0004 -> 0x12345678; then 5 idle cycles -> rdata held at 0x12345678.

Source files
------------

// File: rtl/data_sram_responder_pkg.sv
// data_sram_responder_pkg: shared constants, state type and wen legality check for the data SRAM responder
package data_sram_responder_pkg;
  localparam int WAIT_W = 4;
  localparam int STALL_BUS_IDX = 3;
  localparam logic [3:0] WEN_RD = 4'b0000;
  localparam logic [3:0] WEN_B0 = 4'b0001;
  localparam logic [3:0] WEN_B1 = 4'b0010;
  localparam logic [3:0] WEN_B2 = 4'b0100;
  localparam logic [3:0] WEN_B3 = 4'b1000;
  localparam logic [3:0] WEN_H0 = 4'b0011;
  localparam logic [3:0] WEN_H1 = 4'b1100;
  localparam logic [3:0] WEN_W  = 4'b1111;

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic logic wen_legal(input logic [3:0] w);
    return w inside {WEN_RD, WEN_B0, WEN_B1, WEN_B2, WEN_B3, WEN_H0, WEN_H1, WEN_W};
  endfunction
endpackage

// File: rtl/data_sram_array.sv
// data_sram_array: word RAM with byte-lane writes and a registered, resettable read port
module data_sram_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [2**ADDR_W];

  // byte-lane write; contents are deliberately left unreset
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];

  // read register only moves on a completed read so a stalled consumer re-samples the same value
  always_ff @(posedge clk or negedge rst)
    if (!rst) rdata <= '0;
    else if (rd) rdata <= mem[idx];
endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: data-side SRAM responder with optional wait states, stall request and illegal-wen flag
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_for_mem,
  output logic        data_sram_err
);
  localparam bit HAS_WAIT = WAIT_CYCLES != 0;

  state_t              state;
  logic [WAIT_W-1:0]   cnt;
  logic [3:0]          l_wen;
  logic [ADDR_W-1:0]   l_idx;
  logic [31:0]         l_wdata;
  logic                acc;
  logic [3:0]          a_wen;
  logic [ADDR_W-1:0]   a_idx;
  logic [31:0]         a_wdata;
  logic                a_legal;
  logic                unused;

  assign unused = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  // the access fires either straight from IDLE (no wait states) or on the last BUSY edge using latched request
  always_comb begin
    acc     = (state == IDLE && data_sram_en && !HAS_WAIT) || (state == BUSY && cnt == WAIT_W'(1));
    a_wen   = state == BUSY ? l_wen : data_sram_wen;
    a_idx   = state == BUSY ? l_idx : data_sram_addr[ADDR_W+1:2];
    a_wdata = state == BUSY ? l_wdata : data_sram_wdata;
    a_legal = wen_legal(a_wen);
    stallreq_for_mem = (state == IDLE && data_sram_en && HAS_WAIT) || (state == BUSY && cnt > WAIT_W'(1));
  end

  data_sram_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .rst   (rst),
    .rd    (acc && a_wen == WEN_RD),
    .we    (acc && a_legal ? a_wen : 4'b0000),
    .idx   (a_idx),
    .wdata (a_wdata),
    .rdata (data_sram_rdata)
  );

  // request FSM: latch on accept, count down wait states, flag illegal wen once the access completes
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      l_wen         <= '0;
      l_idx         <= '0;
      l_wdata       <= '0;
      data_sram_err <= 1'b0;
    end else begin
      data_sram_err <= acc && !a_legal;
      if (state == IDLE) begin
        if (data_sram_en && HAS_WAIT) begin
          state   <= BUSY;
          cnt     <= WAIT_W'(WAIT_CYCLES);
          l_wen   <= data_sram_wen;
          l_idx   <= data_sram_addr[ADDR_W+1:2];
          l_wdata <= data_sram_wdata;
        end
      end else begin
        cnt <= cnt - WAIT_W'(1);
        if (cnt == WAIT_W'(1)) state <= IDLE;
      end
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: directed self-checking bench for a zero-wait and a three-wait responder
module tb_data_sram_responder;
  logic clk = 0, rst = 0;
  logic en0 = 0, en3 = 0;
  logic [3:0] wen0 = 0, wen3 = 0;
  logic [31:0] addr0 = 0, addr3 = 0, wdata0 = 0, wdata3 = 0;
  logic [31:0] rdata0, rdata3;
  logic stall0, stall3, err0, err3;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) d0 (
    .clk(clk), .rst(rst), .data_sram_en(en0), .data_sram_wen(wen0), .data_sram_addr(addr0),
    .data_sram_wdata(wdata0), .data_sram_rdata(rdata0), .stallreq_for_mem(stall0), .data_sram_err(err0));

  data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) d3 (
    .clk(clk), .rst(rst), .data_sram_en(en3), .data_sram_wen(wen3), .data_sram_addr(addr3),
    .data_sram_wdata(wdata3), .data_sram_rdata(rdata3), .stallreq_for_mem(stall3), .data_sram_err(err3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc0(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en0 = 1; wen0 = w; addr0 = a; wdata0 = d;
    tick();
    en0 = 0; wen0 = 0;
  endtask

  task automatic acc3(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en3 = 1; wen3 = w; addr3 = a; wdata3 = d;
    tick();
    en3 = 0; wen3 = 0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    #3;
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0 got %h exp 0", rdata0); end
    checks++; if (stall0 !== 1'b0 || err0 !== 1'b0) begin errors++; $display("FAIL reset_flags0 got stall=%b err=%b exp 0 0", stall0, err0); end
    checks++; if (rdata3 !== 32'h0 || stall3 !== 1'b0 || err3 !== 1'b0) begin errors++; $display("FAIL reset_d3 got rdata=%h stall=%b err=%b exp 0 0 0", rdata3, stall3, err3); end
    tick();
    rst = 1;
    tick();
  endtask

  task automatic test_basic();
    en0 = 1; wen0 = 4'b1111; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
    #1;
    checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL basic_stall_write got %b exp 0", stall0); end
    tick();
    en0 = 0; wen0 = 0;
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL basic_write_no_rdata got %h exp 0", rdata0); end
    en0 = 1; addr0 = 32'h10;
    #1;
    checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL basic_stall_read got %b exp 0", stall0); end
    tick();
    en0 = 0;
    checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_read got %h exp deadbeef", rdata0); end
  endtask

  task automatic test_lanes();
    acc0(4'b1111, 32'h20, 32'h11223344);
    acc0(4'b0001, 32'h20, 32'h000000AA);
    acc0(4'b1100, 32'h20, 32'hBBBB0000);
    checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL lanes_rdata_held got %h exp deadbeef", rdata0); end
    acc0(4'b0000, 32'h22, 32'h0);
    checks++; if (rdata0 !== 32'hBBBB33AA) begin errors++; $display("FAIL lanes_read got %h exp bbbb33aa", rdata0); end
  endtask

  task automatic test_wait3();
    acc3(4'b1111, 32'h10, 32'hDEADBEEF);
    en3 = 1; wen3 = 4'b0000; addr3 = 32'h10; wdata3 = 32'h0;
    #1;
    checks++; if (stall3 !== 1'b1) begin errors++; $display("FAIL wait_stall_accept got %b exp 1", stall3); end
    tick();
    wen3 = 4'b1111; addr3 = 32'h10; wdata3 = 32'h0;
    checks++; if (stall3 !== 1'b1 || rdata3 !== 32'h0) begin errors++; $display("FAIL wait_cnt3 got stall=%b rdata=%h exp 1 0", stall3, rdata3); end
    tick();
    checks++; if (stall3 !== 1'b1) begin errors++; $display("FAIL wait_cnt2 got %b exp 1", stall3); end
    tick();
    checks++; if (stall3 !== 1'b0 || rdata3 !== 32'h0) begin errors++; $display("FAIL wait_cnt1 got stall=%b rdata=%h exp 0 0", stall3, rdata3); end
    en3 = 0; wen3 = 0;
    tick();
    checks++; if (stall3 !== 1'b0 || rdata3 !== 32'hDEADBEEF) begin errors++; $display("FAIL wait_done got stall=%b rdata=%h exp 0 deadbeef", stall3, rdata3); end
    acc3(4'b0000, 32'h10, 32'h0);
    checks++; if (rdata3 !== 32'hDEADBEEF) begin errors++; $display("FAIL wait_busy_ignored got %h exp deadbeef", rdata3); end
  endtask

  task automatic test_err();
    acc0(4'b0000, 32'h10, 32'h0);
    en0 = 1; wen0 = 4'b0101; addr0 = 32'h20; wdata0 = 32'hFFFFFFFF;
    #1;
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL err_before got %b exp 0", err0); end
    tick();
    en0 = 0; wen0 = 0;
    checks++; if (err0 !== 1'b1 || rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL err_pulse got err=%b rdata=%h exp 1 deadbeef", err0, rdata0); end
    tick();
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL err_one_cycle got %b exp 0", err0); end
    acc0(4'b0000, 32'h20, 32'h0);
    checks++; if (rdata0 !== 32'hBBBB33AA) begin errors++; $display("FAIL err_no_write got %h exp bbbb33aa", rdata0); end
    en3 = 1; wen3 = 4'b0110; addr3 = 32'h10; wdata3 = 32'h0;
    tick();
    en3 = 0; wen3 = 0;
    tick(); tick();
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL err3_early got %b exp 0", err3); end
    tick();
    checks++; if (err3 !== 1'b1) begin errors++; $display("FAIL err3_pulse got %b exp 1", err3); end
    tick();
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL err3_one_cycle got %b exp 0", err3); end
  endtask

  task automatic test_alias();
    acc0(4'b1111, 32'h1004, 32'h12345678);
    acc0(4'b0000, 32'h0004, 32'h0);
    checks++; if (rdata0 !== 32'h12345678) begin errors++; $display("FAIL alias_read got %h exp 12345678", rdata0); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (rdata0 !== 32'h12345678) begin errors++; $display("FAIL hold_idle%0d got %h exp 12345678", i, rdata0); end
    end
  endtask

  task automatic test_reset_busy();
    acc3(4'b1111, 32'h30, 32'h0);
    acc3(4'b0000, 32'h10, 32'h0);
    en3 = 1; wen3 = 4'b1111; addr3 = 32'h30; wdata3 = 32'h55555555;
    tick();
    en3 = 0; wen3 = 0;
    checks++; if (stall3 !== 1'b1) begin errors++; $display("FAIL rstbusy_pending got %b exp 1", stall3); end
    rst = 0;
    #1;
    checks++; if (stall3 !== 1'b0 || rdata3 !== 32'h0 || err3 !== 1'b0) begin errors++; $display("FAIL rstbusy_async got stall=%b rdata=%h err=%b exp 0 0 0", stall3, rdata3, err3); end
    tick(); tick();
    rst = 1;
    tick();
    acc3(4'b0000, 32'h10, 32'h0);
    checks++; if (rdata3 !== 32'hDEADBEEF) begin errors++; $display("FAIL rstbusy_ram_kept got %h exp deadbeef", rdata3); end
    acc3(4'b0000, 32'h30, 32'h0);
    checks++; if (rdata3 !== 32'h0) begin errors++; $display("FAIL rstbusy_no_write got %h exp 0", rdata3); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lanes();
    test_wait3();
    test_err();
    test_alias();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
